inst_mem_responder: RTL and testbench

Instruction-memory responder serving fetch requests issued by the fetch stage.
- Accepts one word-address request at a time and returns the instruction word after a configurable number of wait states.
- Asserts busy during wait states; busy drives the fetch stage's freeze.
- Aborts an in-flight access on flush (branch taken), so a stale instruction is never delivered.

---
 rtl/inst_mem_responder_pkg.sv | 15 +
 rtl/inst_mem_array.sv | 26 ++
 rtl/inst_mem_responder.sv | 136 +++++++++++++
 tb/tb_inst_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_responder_pkg.sv
// Shared types for the instruction-memory responder.
// State encoding, wait counter width and the error fill word.
package inst_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/inst_mem_array.sv
// Word-addressed storage with one synchronous write port and
// one combinational read port.
module inst_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: one fetch at a time, fixed wait
// states, flush abort, busy freezes the fetch stage.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [31:0]       prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              busy,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [31:0]       resp_addr,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [31:0]       raddr_q, raddr_d;
  logic              err_q, err_d;

  logic              accept;
  logic              load;
  logic [31:0]       cap_addr;
  logic              cap_err;
  logic              prog_ok;
  logic [DATA_W-1:0] arr_rdata;
  logic              unused_prog_lo;

  assign accept = req_valid && !flush && (state_q != WAIT);

  // With zero wait states the capture happens on the accept edge,
  // before addr_q holds the new address.
  assign cap_addr = accept ? req_addr : addr_q;
  assign cap_err  = (cap_addr[1:0] != 2'b00) ||
                    (cap_addr[31:2] >= DEPTH_W);

  assign prog_ok = prog_we && (prog_addr[31:2] < DEPTH_W);
  assign unused_prog_lo = ^prog_addr[1:0];

  inst_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (prog_ok),
    .waddr_i (prog_addr[AW+1:2]),
    .wdata_i (prog_data),
    .raddr_i (cap_addr[AW+1:2]),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          addr_d = req_addr;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            load    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    raddr_d = raddr_q;
    err_d   = err_q;
    if (load) begin
      rdata_d = cap_err ? DATA_W'(NOP_WORD) : arr_rdata;
      raddr_d = cap_addr;
      err_d   = cap_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      raddr_q <= raddr_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q == WAIT);
  assign resp_valid = (state_q == RESP) && !flush;
  assign resp_data  = rdata_q;
  assign resp_addr  = raddr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench: WAIT_CYCLES=2 instance plus a
// WAIT_CYCLES=0 instance for the zero-latency path.
module tb_inst_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, flush, prog_we;
  logic [31:0] req_addr, prog_addr, prog_data;
  logic        busy, resp_valid, err;
  logic [31:0] resp_data, resp_addr;

  logic        z_req_valid, z_flush, z_prog_we;
  logic [31:0] z_req_addr, z_prog_addr, z_prog_data;
  logic        z_busy, z_resp_valid, z_err;
  logic [31:0] z_resp_data, z_resp_addr;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q2[$];
  exp_t q0[$];
  exp_t e2, e0;
  logic z_busy_seen = 1'b0;

  inst_mem_responder #(
    .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .flush(flush),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data),
    .busy(busy), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_addr(resp_addr),
    .err(err)
  );

  inst_mem_responder #(
    .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_addr(z_req_addr),
    .flush(z_flush),
    .prog_we(z_prog_we), .prog_addr(z_prog_addr),
    .prog_data(z_prog_data),
    .busy(z_busy), .resp_valid(z_resp_valid),
    .resp_data(z_resp_data), .resp_addr(z_resp_addr),
    .err(z_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL w2_unexpected: resp addr=%h data=%h cyc=%0d",
                 resp_addr, resp_data, cyc);
      end else begin
        e2 = q2.pop_front();
        if (resp_data !== e2.data || resp_addr !== e2.addr ||
            err !== e2.err || cyc != e2.at) begin
          bad++;
          $display("FAIL w2_resp: got d=%h a=%h e=%b c=%0d want d=%h a=%h e=%b c=%0d",
                   resp_data, resp_addr, err, cyc,
                   e2.data, e2.addr, e2.err, e2.at);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (z_busy === 1'b1) z_busy_seen = 1'b1;
    if (z_resp_valid === 1'b1) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL w0_unexpected: resp addr=%h data=%h cyc=%0d",
                 z_resp_addr, z_resp_data, cyc);
      end else begin
        e0 = q0.pop_front();
        if (z_resp_data !== e0.data || z_resp_addr !== e0.addr ||
            z_err !== e0.err || cyc != e0.at) begin
          bad++;
          $display("FAIL w0_resp: got d=%h a=%h e=%b c=%0d want d=%h a=%h e=%b c=%0d",
                   z_resp_data, z_resp_addr, z_err, cyc,
                   e0.data, e0.addr, e0.err, e0.at);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog2(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  // Request accepted on the next edge; response due WAIT_CYCLES later.
  task automatic issue2(input logic [31:0] a, input logic [31:0] d,
                        input logic e);
    req_valid = 1'b1; req_addr = a;
    step();
    q2.push_back('{data: d, addr: a, err: e, at: cyc + 2});
    req_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 0; flush = 0; prog_we = 0;
    req_addr = 0; prog_addr = 0; prog_data = 0;
    z_req_valid = 0; z_flush = 0; z_prog_we = 0;
    z_req_addr = 0; z_prog_addr = 0; z_prog_data = 0;
    step(); step();

    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_addr", resp_addr, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_z_busy", 32'(z_busy), 0);
    rst = 1'b1;

    prog2(32'h0,   32'hA5A5A5A5);
    prog2(32'h4,   32'hE3A01005);
    prog2(32'h8,   32'h12345678);
    prog2(32'h3FC, 32'hCAFEF00D);
    prog2(32'h400, 32'hFFFFFFFF);

    issue2(32'h4, 32'hE3A01005, 1'b0);
    chk("wait1_busy", 32'(busy), 1);
    step();
    chk("wait2_busy", 32'(busy), 1);
    step();
    chk("resp_busy", 32'(busy), 0);
    issue2(32'h8, 32'h12345678, 1'b0);
    chk("b2b_busy", 32'(busy), 1);
    drain(3);

    req_valid = 1'b1; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_wait_busy", 32'(busy), 0);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
    step();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_req_busy", 32'(busy), 0);
    step();
    chk("flush_idle_busy", 32'(busy), 0);
    step();

    issue2(32'h6,   32'h0, 1'b1);
    drain(3);
    issue2(32'h400, 32'h0, 1'b1);
    drain(3);
    issue2(32'h3FC, 32'hCAFEF00D, 1'b0);
    drain(3);
    issue2(32'h0,   32'hA5A5A5A5, 1'b0);
    drain(3);

    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_resp_valid", 32'(resp_valid), 0);
    chk("midrst_resp_addr", resp_addr, 0);
    drain(3);
    issue2(32'h4, 32'hE3A01005, 1'b0);
    drain(3);

    req_valid = 1'b1; req_addr = 32'h8;
    step();
    req_valid = 1'b0;
    step(); step();
    flush = 1'b1;
    #1;
    chk("flush_resp_valid", 32'(resp_valid), 0);
    step();
    flush = 1'b0;
    drain(2);

    z_prog_we = 1'b1; z_prog_addr = 32'h0; z_prog_data = 32'h11111111;
    step();
    z_req_valid = 1'b1; z_req_addr = 32'h0;
    z_prog_data = 32'h22222222;
    step();
    q0.push_back('{data: 32'h11111111, addr: 32'h0, err: 1'b0, at: cyc});
    z_req_valid = 1'b0; z_prog_we = 1'b0;
    chk("z_resp_busy", 32'(z_busy), 0);
    step();
    z_req_valid = 1'b1;
    step();
    q0.push_back('{data: 32'h22222222, addr: 32'h0, err: 1'b0, at: cyc});
    z_req_valid = 1'b0;
    drain(3);

    chk("z_busy_never", 32'(z_busy_seen), 0);
    chk("w2_queue_empty", 32'(q2.size()), 0);
    chk("w0_queue_empty", 32'(q0.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
